// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock key entry path: FSM state codes
// and the keypad "no key pressed" code.
package alarm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t SHOW_TIME  = 3'd0;
    localparam state_t KEY_STORED = 3'd1;
    localparam state_t KEY_WAITED = 3'd2;
    localparam state_t KEY_ENTRY  = 3'd3;
    localparam state_t SHOW_ALARM = 3'd4;
    localparam state_t SET_ALARM  = 3'd5;
    localparam state_t SET_TIME   = 3'd6;

    localparam logic [3:0] NOKEY = 4'd10;

endpackage

// File: rtl/key_timeout_cnt.sv
// Saturating event counter with synchronous clear. Used both as the
// keypad-inactivity timer (ticked by the one-second pulse) and as the
// digit counter (tick tied high, enabled once per key press).
module key_timeout_cnt #(
    parameter int            W     = 4,
    parameter logic [W-1:0]  LIMIT = W'(10)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic         i_tick,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count enabled ticks, holding at LIMIT; clear or reset returns to zero.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && i_tick && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/key_entry_ctrl.sv
// Moore FSM sequencing the alarm-clock key buffer: one active-low shift
// strobe per keypad press, inactivity timeout, and commit of the buffered
// digits into the alarm or current-time registers.
module key_entry_ctrl #(
    parameter int          TIMEOUT_SEC = 10,
    parameter logic [3:0]  NOKEY       = alarm_pkg::NOKEY,
    parameter int          DIGITS      = 4,
    parameter int          CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c
);

    import alarm_pkg::*;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   w_tcount;
    logic [CNT_W-1:0]   w_dcount;
    logic               w_timeout;
    logic               w_fullEntry;
    logic               w_keyDown;
    logic               w_tClear;
    logic               w_tEnable;
    logic               w_dClear;
    logic               w_dEnable;

    assign w_keyDown   = (key != NOKEY);
    assign w_timeout   = (w_tcount == CNT_W'(TIMEOUT_SEC));
    assign w_fullEntry = (w_dcount == CNT_W'(DIGITS));

    // A fresh press passes through KEY_STORED, which restarts the window;
    // ticks landing in that cycle are dropped.
    assign w_tClear  = (r_state == SHOW_TIME) || (r_state == KEY_STORED);
    assign w_tEnable = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);

    assign w_dClear  = (r_state == SHOW_TIME);
    assign w_dEnable = (r_state == KEY_STORED);

    key_timeout_cnt #(
        .W     (CNT_W),
        .LIMIT (CNT_W'(TIMEOUT_SEC))
    ) u_tcount (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_tClear),
        .i_enable (w_tEnable),
        .i_tick   (one_second),
        .o_count  (w_tcount)
    );

    key_timeout_cnt #(
        .W     (CNT_W),
        .LIMIT (CNT_W'(DIGITS))
    ) u_dcount (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_dClear),
        .i_enable (w_dEnable),
        .i_tick   (1'b1),
        .o_count  (w_dcount)
    );

    // Next-state selection; within each state, buttons beat keys and keys beat timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SHOW_TIME: begin
                if (alarm_button)      w_nextState = SHOW_ALARM;
                else if (w_keyDown)    w_nextState = KEY_STORED;
            end
            KEY_STORED: begin
                w_nextState = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!w_keyDown)        w_nextState = KEY_ENTRY;
                else if (w_timeout)    w_nextState = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)      w_nextState = w_fullEntry ? SET_ALARM : SHOW_TIME;
                else if (time_button)  w_nextState = w_fullEntry ? SET_TIME : SHOW_TIME;
                else if (w_keyDown)    w_nextState = KEY_STORED;
                else if (w_timeout)    w_nextState = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button)     w_nextState = SHOW_TIME;
            end
            SET_ALARM: begin
                w_nextState = SHOW_TIME;
            end
            SET_TIME: begin
                w_nextState = SHOW_TIME;
            end
            default: begin
                w_nextState = SHOW_TIME;
            end
        endcase
    end

    // State register; reset forces the time display regardless of inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SHOW_TIME;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign shift         = (r_state != KEY_STORED);
    assign show_new_time = (r_state == KEY_STORED) || (r_state == KEY_WAITED) ||
                           (r_state == KEY_ENTRY)  || (r_state == SET_ALARM)  ||
                           (r_state == SET_TIME);
    assign show_a        = (r_state == SHOW_ALARM);
    assign load_new_a    = (r_state == SET_ALARM);
    assign load_new_c    = (r_state == SET_TIME);

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Moore FSM that sequences the alarm-clock key buffer. It detects each new keypad press and issues exactly one active-low shift strobe per press into the 4-digit key shift register. It times out abandoned entries using the one-second tick, and on alarm/time button commits the buffered digits as new alarm or new current time. Sits between the keypad decoder, the key shift register, the display mux and the alarm/time registers.

Parameters:
TIMEOUT_SEC, 10, one-second ticks of keypad inactivity before abandoning entry
NOKEY, 4'd10, key code meaning "no key pressed"; 0-9 are digits
DIGITS, 4, digits required before a commit is accepted
CNT_W, 4, width of timeout and digit counters; must hold max(TIMEOUT_SEC, DIGITS)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
one_second  in  1  single-cycle tick, once per second
key  in  4  decoded keypad value, NOKEY when idle
alarm_button  in  1  level, high while alarm button held
time_button  in  1  level, high while time button held
shift  out  1  active-low shift strobe to key shift register (idle 1)
show_new_time  out  1  display selects key buffer
show_a  out  1  display selects alarm time
load_new_a  out  1  one-cycle load of key buffer into alarm register
load_new_c  out  1  one-cycle load of key buffer into current-time counter

Behaviour:
- All outputs decoded from registered state only (Moore); no input-to-output combinational path.
- Reset (sampled at clock edge): state=SHOW_TIME, tcount=0, dcount=0; shift=1, all other outputs 0. Reset in any state, including mid-entry, wins over all inputs.
- States and transitions (priority listed highest first):
  - SHOW_TIME: alarm_button -> SHOW_ALARM; key!=NOKEY -> KEY_STORED; else stay.
  - KEY_STORED: unconditional -> KEY_WAITED; shift=0 in this state only (exactly one cycle per press).
  - KEY_WAITED (key still held): key==NOKEY -> KEY_ENTRY; timeout -> SHOW_TIME; else stay. No re-shift while held.
  - KEY_ENTRY: alarm_button -> (dcount==DIGITS ? SET_ALARM : SHOW_TIME); time_button -> (dcount==DIGITS ? SET_TIME : SHOW_TIME); key!=NOKEY -> KEY_STORED; timeout -> SHOW_TIME; else stay.
  - SHOW_ALARM: alarm_button==0 -> SHOW_TIME; else stay.
  - SET_ALARM: load_new_a=1 for one cycle -> SHOW_TIME.
  - SET_TIME: load_new_c=1 for one cycle -> SHOW_TIME.
- show_new_time=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM, SET_TIME. show_a=1 in SHOW_ALARM only.
- Timeout counter tcount:
  - Cleared in SHOW_TIME and KEY_STORED.
  - Increments on one_second while in KEY_WAITED or KEY_ENTRY; saturates at TIMEOUT_SEC.
  - timeout = (tcount==TIMEOUT_SEC).
  - Any new key restarts the timeout window; a tick in the KEY_STORED cycle is ignored.
- Digit counter dcount:
  - Cleared in SHOW_TIME.
  - Increments in KEY_STORED; saturates at DIGITS. More than DIGITS presses keep shifting, so the last DIGITS keys are kept.
- Simultaneous events:
  - Button and key in the same cycle: button wins.
  - Key and timeout in the same cycle: key wins.
  - alarm_button and time_button together: alarm wins.
- On abandoned entry (timeout or short commit), the shift register contents are left untouched; only the display reverts.

Decomposition:
- Shared package alarm_pkg: state enum (SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM, SET_TIME) and constant NOKEY.
- Sub-module key_timeout_cnt: saturating tick counter with clear/enable, giving tcount and timeout. Reused for dcount with tick tied high and a different limit.
- FSM next-state and output decode stay in key_entry_ctrl.

Test Plan:
- Reset mid-entry: after 2 digits, pulse reset -> next cycle state SHOW_TIME, shift=1, show_new_time=0, dcount=0.
- Key sequence 1,2,3,4 (each held 5 cycles, NOKEY gaps 3 cycles), then time_button -> exactly 4 single-cycle shift=0 strobes; load_new_c=1 for one cycle; load_new_a stays 0.
- Key 7 held 20 cycles -> exactly one shift=0 strobe; show_new_time=1 throughout.
- Enter 2 digits, then alarm_button -> no load_new_a; return to SHOW_TIME next cycle.
- Enter 1 digit, idle with 10 one_second ticks -> on the 10th tick state returns to SHOW_TIME, show_new_time drops. With key 5 arriving on the same cycle as the 10th tick -> KEY_STORED and shift=0 instead.
- From SHOW_TIME, hold alarm_button 8 cycles -> show_a=1 from the cycle after press until the cycle after release; a key pressed meanwhile gives no shift strobe.
